// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and line constants,
// common to the buffered transmitter and its companion receiver.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between a producer and the buffered UART transmitter.
// A byte moves on any rising clock edge where tx_dv && tx_ready.
interface uart_tx_if;

    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_ready;

    modport master (output tx_dv, output tx_byte, input  tx_ready);
    modport slave  (input  tx_dv, input  tx_byte, output tx_ready);

endinterface

// File: rtl/uart_tx_buffered_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and strobes
// o_Bit_End on the last clock of each bit. Held at zero while disabled.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_En,
    output logic o_Bit_End
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (i_En && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign o_Bit_End = i_En && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a one-entry holding register ahead of the shifter.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_ODD   = 0
) (
    input  logic      i_Clock,
    input  logic      i_Rst_n,
    uart_tx_if.slave  tx_if,
    output logic      o_Tx_Serial,
    output logic      o_Tx_Active,
    output logic      o_Tx_Done
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx_buffered: CLKS_PER_BIT must be >= 2");
        end
        if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_par
            $error("uart_tx_buffered: PARITY_ODD must be 0 or 1");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_BIT = (PARITY_ODD != 0);
`endif

    uart_tx_state_t state_q, state_d;
    logic [7:0]     hold_q, hold_d;
    logic           hold_valid_q, hold_valid_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic           serial_q, serial_d;
    logic           bit_end;
    logic           load;
    logic           tx_done;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .i_Clock   (i_Clock),
        .i_Rst_n   (i_Rst_n),
        .i_En      (state_q != ST_IDLE),
        .o_Bit_End (bit_end)
    );

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        load         = 1'b0;
        tx_done      = 1'b0;

        case (state_q)
            ST_IDLE:  if (hold_valid_q) load = 1'b1;
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
            ST_STOP: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    // A queued byte chains straight into the next start bit.
                    if (hold_valid_q) load = 1'b1;
                    else              state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d      = ST_START;
            shift_d      = hold_q;
            bit_idx_d    = 3'd0;
            hold_valid_d = 1'b0;
        end

        // Accept only into an empty hold, so it never coincides with a load.
        if (tx_if.tx_dv && !hold_valid_q) begin
            hold_d       = tx_if.tx_byte;
            hold_valid_d = 1'b1;
        end
    end

    // Line level follows the next state so the registered output lines up with state_q.
    always_comb begin
        serial_d = UART_IDLE_LVL;
        case (state_d)
            ST_START:  serial_d = ~UART_IDLE_LVL;
            ST_DATA:   serial_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: serial_d = (^shift_d) ^ PAR_BIT;
`endif
            default:   serial_d = UART_IDLE_LVL;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            serial_q     <= UART_IDLE_LVL;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            serial_q     <= serial_d;
        end
    end

    assign tx_if.tx_ready = !hold_valid_q;
    assign o_Tx_Serial    = serial_q;
    assign o_Tx_Active    = (state_q != ST_IDLE);
    assign o_Tx_Done      = tx_done;

endmodule
